// File: rtl/spi_ram_if.sv
// spi_ram_if: command/response bundle between the SPI slave and the RAM.
interface spi_ram_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       seq_err;
    modport master (output din, rx_valid, input dout, tx_valid, seq_err);
    modport slave (input din, rx_valid, output dout, tx_valid, seq_err);
endinterface

// File: rtl/spi_ram.sv
// spi_ram: command-decoding RAM behind the SPI slave, with address-valid sequencing checks.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input logic       clk,
    input logic       rst_n,
    spi_ram_if.slave  bus
);
    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, field;
    logic [7:0]           dout_q, dout_d;
    logic                 wa_ok_q, wa_ok_d, ra_ok_q, ra_ok_d;
    logic                 tx_valid_q, tx_valid_d, seq_err_q, seq_err_d;
    logic [1:0]           op;
    logic                 wa_cmd, ra_cmd, wr_en, rd_en;
    assign op     = bus.din[9:8];
    assign field  = bus.din[ADDR_SIZE-1:0];
    assign wa_cmd = bus.rx_valid && op == 2'b00;
    assign ra_cmd = bus.rx_valid && op == 2'b10;
    assign wr_en  = bus.rx_valid && op == 2'b01 && wa_ok_q;
    assign rd_en  = bus.rx_valid && op == 2'b11 && ra_ok_q;
    always_comb begin
        wr_addr_d  = wa_cmd ? field : (wr_en && AUTO_INC != 0) ? wr_addr_q + 1'b1 : wr_addr_q;
        rd_addr_d  = ra_cmd ? field : (rd_en && AUTO_INC != 0) ? rd_addr_q + 1'b1 : rd_addr_q;
        wa_ok_d    = wa_ok_q | wa_cmd;
        ra_ok_d    = ra_ok_q | ra_cmd;
        dout_d     = rd_en ? mem[rd_addr_q] : dout_q;
        tx_valid_d = rd_en;
        // data command without a prior address command of the same direction
        seq_err_d  = bus.rx_valid && op[0] && !(op[1] ? ra_ok_q : wa_ok_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wa_ok_q    <= 1'b0;
            ra_ok_q    <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wa_ok_q    <= wa_ok_d;
            ra_ok_q    <= ra_ok_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            seq_err_q  <= seq_err_d;
        end
    end
    // memory contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr_q] <= bus.din[7:0];
    end
    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.seq_err  = seq_err_q;
endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: drives one command stream into AUTO_INC=0 and AUTO_INC=1 instances against a behavioural model.
module tb_spi_ram;
    localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    bit         chk_on = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] m [2][256];
    bit         kn [2][256];
    logic [7:0] wa [2], ra [2], edout [2];
    bit         wok [2], rok [2], etx [2], eerr [2], edk [2];
    spi_ram_if b0 ();
    spi_ram_if b1 ();
    assign b0.din = din;
    assign b0.rx_valid = rx_valid;
    assign b1.din = din;
    assign b1.rx_valid = rx_valid;
    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    always #5 clk = ~clk;
    task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s u%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask
    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            wa[k] = 8'h00; ra[k] = 8'h00; wok[k] = 1'b0; rok[k] = 1'b0;
            edout[k] = 8'h00; edk[k] = 1'b1; etx[k] = 1'b0; eerr[k] = 1'b0;
        end
    endfunction
    function automatic void model_apply(input logic [1:0] op, input logic [7:0] d, input bit v);
        for (int k = 0; k < 2; k++) begin
            etx[k] = 1'b0;
            eerr[k] = 1'b0;
            if (v) begin
                case (op)
                    WA: begin wa[k] = d; wok[k] = 1'b1; end
                    WD: if (wok[k]) begin
                            m[k][wa[k]] = d; kn[k][wa[k]] = 1'b1;
                            if (k == 1) wa[k] = wa[k] + 8'd1;
                        end else eerr[k] = 1'b1;
                    RA: begin ra[k] = d; rok[k] = 1'b1; end
                    default: if (rok[k]) begin
                            edout[k] = m[k][ra[k]]; edk[k] = kn[k][ra[k]]; etx[k] = 1'b1;
                            if (k == 1) ra[k] = ra[k] + 8'd1;
                        end else eerr[k] = 1'b1;
                endcase
            end
        end
    endfunction
    task automatic issue(input logic [1:0] op, input logic [7:0] d, input bit v = 1'b1);
        din = {op, d};
        rx_valid = v;
        @(posedge clk);
        model_apply(op, d, v);
        #1;
        rx_valid = 1'b0;
    endtask
    task automatic reset_for(input int n);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        model_reset();
        check("async_rst_tx0", 0, {7'd0, b0.tx_valid}, 8'h00);
        check("async_rst_dout", 1, b1.dout, 8'h00);
        check("async_rst_err", 1, {7'd0, b1.seq_err}, 8'h00);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    always @(negedge clk) begin
        if (chk_on) begin
            check("tx_valid", 0, {7'd0, b0.tx_valid}, {7'd0, etx[0]});
            check("seq_err", 0, {7'd0, b0.seq_err}, {7'd0, eerr[0]});
            if (edk[0]) check("dout", 0, b0.dout, edout[0]);
            check("tx_valid", 1, {7'd0, b1.tx_valid}, {7'd0, etx[1]});
            check("seq_err", 1, {7'd0, b1.seq_err}, {7'd0, eerr[1]});
            if (edk[1]) check("dout", 1, b1.dout, edout[1]);
        end
    end
    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) kn[k][a] = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", 0, b0.dout, 8'h00);
        check("reset_tx", 0, {7'd0, b0.tx_valid}, 8'h00);
        chk_on = 1'b1;
        rst_n = 1'b1;
        // seed address 0, then reset so data commands arrive with no valid address
        issue(WA, 8'h00);
        issue(WD, 8'h33);
        reset_for(2);
        issue(WD, 8'h11);
        check("lit_err_wd", 0, {7'd0, b0.seq_err}, 8'h01);
        issue(RD, 8'h00);
        check("lit_err_rd", 1, {7'd0, b1.seq_err}, 8'h01);
        check("lit_no_tx", 0, {7'd0, b0.tx_valid}, 8'h00);
        check("lit_dout_hold", 0, b0.dout, 8'h00);
        issue(RA, 8'h00);
        issue(RD, 8'h00);
        check("lit_mem0_kept", 0, b0.dout, 8'h33);
        check("lit_mem0_kept", 1, b1.dout, 8'h33);
        issue(WA, 8'h3C);
        issue(WD, 8'hA5);
        issue(RA, 8'h3C);
        issue(RD, 8'h00);
        check("lit_rd_a5", 0, b0.dout, 8'hA5);
        check("lit_rd_a5_tx", 0, {7'd0, b0.tx_valid}, 8'h01);
        check("model_a5", 0, edout[0], 8'hA5);
        issue(RD, 8'h00, 1'b0);
        check("lit_tx_one_cycle", 0, {7'd0, b0.tx_valid}, 8'h00);
        check("lit_dout_held", 0, b0.dout, 8'hA5);
        issue(WA, 8'h20);
        issue(RA, 8'h20);
        issue(WD, 8'h77);
        issue(RD, 8'h00);
        check("lit_write_first", 0, b0.dout, 8'h77);
        check("lit_write_first", 1, b1.dout, 8'h77);
        issue(WA, 8'hFF);
        issue(WD, 8'h01);
        issue(WD, 8'h02);
        issue(RA, 8'hFF);
        issue(RD, 8'h00);
        check("lit_inc_ff", 1, b1.dout, 8'h01);
        check("lit_noinc_ff", 0, b0.dout, 8'h02);
        issue(RD, 8'h00);
        check("lit_inc_wrap", 1, b1.dout, 8'h02);
        check("model_wrap", 1, m[1][0], 8'h02);
        issue(RA, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            issue(RD, 8'h00);
            check("lit_held_rd", 0, b0.dout, 8'hA5);
            check("lit_held_tx", 0, {7'd0, b0.tx_valid}, 8'h01);
        end
        issue(WA, 8'h10);
        issue(WD, 8'h5A);
        reset_for(2);
        issue(WD, 8'h99);
        check("lit_err_after_rst", 0, {7'd0, b0.seq_err}, 8'h01);
        issue(RA, 8'h10);
        issue(RD, 8'h00);
        check("lit_retained", 0, b0.dout, 8'h5A);
        check("lit_retained", 1, b1.dout, 8'h5A);
        repeat (3) issue(WA, 8'h00, 1'b0);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
